// File: rtl/sequenciador_ula_pkg.sv
// Shared definitions for the ULA command sequencer: FSM states, opcode
// constants, default result latency and the latency-counter width helper.
package sequenciador_ula_pkg;

    // Sequencer states: collect opcode, A and B, then wait on the ULA, then deliver.
    typedef enum logic [2:0] {
        ESPERA_OP = 3'd0,
        ESPERA_A  = 3'd1,
        ESPERA_B  = 3'd2,
        EXECUTA   = 3'd3,
        ENTREGA   = 3'd4
    } estado_t;

    localparam logic [2:0] OP_SOMA = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;

    // Default number of ULA cycles from operand drive to a valid result.
    localparam int unsigned LAT_PADRAO = 2;

    // Counter width able to hold LAT without wrapping; at least one bit.
    function automatic int unsigned largura_contador(input int unsigned lat);
        int unsigned w;
        w = (lat == 0) ? 1 : int'($clog2(lat + 1));
        return w;
    endfunction

    // Only add and subtract are considered legal when opcode checking is on.
    function automatic logic opcode_valido(input logic [2:0] op);
        return (op == OP_SOMA) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/sequenciador_ula_if.sv
// Bundle of the command stream, ULA operand/result and delivery signals of
// the sequencer. The slave modport is the sequencer's view; master is the
// view of the environment (command source, ULA and result consumer).
interface sequenciador_ula_if #(
    parameter int unsigned N = 8
);

    // Command byte stream
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;

    // ULA side
    logic [N-1:0] ula_a;
    logic [N-1:0] ula_b;
    logic [2:0]   ula_opcode;
    logic [N-1:0] ula_s;
    logic         ula_flag;

    // Result delivery
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_s;
    logic         out_flag;

    // Status
    logic         busy;
    logic         err;

    modport slave (
        input  in_valid,
        input  in_data,
        input  ula_s,
        input  ula_flag,
        input  out_ready,
        output in_ready,
        output ula_a,
        output ula_b,
        output ula_opcode,
        output out_valid,
        output out_s,
        output out_flag,
        output busy,
        output err
    );

    modport master (
        output in_valid,
        output in_data,
        output ula_s,
        output ula_flag,
        output out_ready,
        input  in_ready,
        input  ula_a,
        input  ula_b,
        input  ula_opcode,
        input  out_valid,
        input  out_s,
        input  out_flag,
        input  busy,
        input  err
    );

endinterface

// File: rtl/sequenciador_ula_contador_latencia.sv
// Saturating latency counter: cleared when operands are latched, counts up
// while enabled and stops at LAT, flagging terminal count there.
module contador_latencia
    import sequenciador_ula_pkg::*;
#(
    parameter int unsigned LAT = LAT_PADRAO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned    CW       = largura_contador(LAT);
    localparam logic [CW-1:0]  TERMINAL = CW'(LAT);

    logic [CW-1:0] r_cnt;

    // Count register: clear has priority, increment holds at TERMINAL so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TERMINAL)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == TERMINAL);

endmodule

// File: rtl/sequenciador_ula.sv
// ULA command sequencer: accepts opcode, A and B bytes on a valid/ready
// stream, drives them to an external ULA, waits LAT cycles and then presents
// the captured result and carry flag until the consumer takes it.
// Optional build macro SEQ_ULA_VALIDA_OPCODE_EN: opcodes other than add/sub
// are rejected in ESPERA_OP with a one-cycle err pulse; otherwise err is 0.
module sequenciador_ula
    import sequenciador_ula_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned LAT = LAT_PADRAO
) (
    input  logic               clk,
    input  logic               rst_n,
    sequenciador_ula_if.slave  bus
);

    estado_t      r_estado;
    estado_t      w_prox;

    logic [2:0]   r_opcode;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_s;
    logic         r_flag;

    logic         w_in_ready;
    logic         w_xfer;
    logic         w_ld_op;
    logic         w_ld_a;
    logic         w_ld_b;
    logic         w_cap;
    logic         w_cnt_en;
    logic         w_tc;

`ifdef SEQ_ULA_VALIDA_OPCODE_EN
    logic         w_rejeita;
    logic         r_err;
`endif

    assign w_in_ready = (r_estado == ESPERA_OP) ||
                        (r_estado == ESPERA_A)  ||
                        (r_estado == ESPERA_B);
    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_cnt_en   = (r_estado == EXECUTA);

    contador_latencia #(
        .LAT (LAT)
    ) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_ld_b),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= ESPERA_OP;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state and load/capture strobes.
    always_comb begin
        w_prox  = r_estado;
        w_ld_op = 1'b0;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        w_cap   = 1'b0;
`ifdef SEQ_ULA_VALIDA_OPCODE_EN
        w_rejeita = 1'b0;
`endif
        unique case (r_estado)
            ESPERA_OP: begin
                if (w_xfer) begin
`ifdef SEQ_ULA_VALIDA_OPCODE_EN
                    if (!opcode_valido(bus.in_data[2:0])) begin
                        w_rejeita = 1'b1;
                    end else begin
                        w_ld_op = 1'b1;
                        w_prox  = ESPERA_A;
                    end
`else
                    w_ld_op = 1'b1;
                    w_prox  = ESPERA_A;
`endif
                end
            end
            ESPERA_A: begin
                if (w_xfer) begin
                    w_ld_a = 1'b1;
                    w_prox = ESPERA_B;
                end
            end
            ESPERA_B: begin
                if (w_xfer) begin
                    w_ld_b = 1'b1;
                    w_prox = EXECUTA;
                end
            end
            EXECUTA: begin
                if (w_tc) begin
                    w_cap  = 1'b1;
                    w_prox = ENTREGA;
                end
            end
            ENTREGA: begin
                if (bus.out_ready) begin
                    w_prox = ESPERA_OP;
                end
            end
            default: begin
                w_prox = ESPERA_OP;
            end
        endcase
    end

    // Operand registers: each one holds until the next command overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            if (w_ld_op) begin
                r_opcode <= bus.in_data[2:0];
            end
            if (w_ld_a) begin
                r_a <= bus.in_data;
            end
            if (w_ld_b) begin
                r_b <= bus.in_data;
            end
        end
    end

    // Result capture: loaded only on the EXECUTA->ENTREGA edge, so it stays
    // stable for the whole delivery handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_flag <= 1'b0;
        end else if (w_cap) begin
            r_s    <= bus.ula_s;
            r_flag <= bus.ula_flag;
        end
    end

`ifdef SEQ_ULA_VALIDA_OPCODE_EN
    // Rejection pulse: high for the single cycle after an illegal opcode byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_rejeita;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.ula_opcode = r_opcode;
    assign bus.ula_a      = r_a;
    assign bus.ula_b      = r_b;
    assign bus.out_valid  = (r_estado == ENTREGA);
    assign bus.out_s      = r_s;
    assign bus.out_flag   = r_flag;
    assign bus.busy       = (r_estado != ESPERA_OP);

endmodule
